// File: rtl/ov7670_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : ov7670_config_sequencer
// Brief   : Walks a fixed OV7670 register table after reset and feeds each
//           {addr,data} write to the SCCB master over its ready/busy handshake.
// Revision: 1.0 - initial release
// ============================================================================
module ov7670_config_sequencer #(
    parameter int ClockFrequency    = 50_000_000,
    parameter int PowerUpDelayMs    = 10,
    parameter int BusyTimeoutCycles = 1024
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       i_start,
    input  logic       i_sccb_busy,
    output logic [7:0] o_sccb_addr,
    output logic [7:0] o_sccb_data,
    output logic       o_sccb_ready,
    output logic [7:0] o_index,
    output logic       o_done,
    output logic       o_error
);

    localparam int c_TICK_CYCLES = ClockFrequency / 1000;
    localparam int c_TICK_W      = (c_TICK_CYCLES > 1) ? $clog2(c_TICK_CYCLES) : 1;
    localparam int c_TO_W        = $clog2(BusyTimeoutCycles + 1);
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(c_TICK_CYCLES - 1);
    localparam logic [7:0]          c_PU_LAST   = 8'(PowerUpDelayMs - 1);
    localparam logic [c_TO_W-1:0]   c_TO_LAST   = c_TO_W'(BusyTimeoutCycles - 1);

    typedef enum logic [2:0] {
        S_POWERUP_WAIT = 3'd0,
        S_FETCH        = 3'd1,
        S_DELAY        = 3'd2,
        S_ISSUE        = 3'd3,
        S_WAIT_BUSY_HI = 3'd4,
        S_WAIT_BUSY_LO = 3'd5,
        S_DONE         = 3'd6,
        S_ERROR        = 3'd7
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [7:0]            r_index, w_index_nxt;
    logic [7:0]            r_addr,  w_addr_nxt;
    logic [7:0]            r_data,  w_data_nxt;
    logic [c_TICK_W-1:0]   r_tick,  w_tick_nxt;
    logic [7:0]            r_ms,    w_ms_nxt;
    logic [c_TO_W-1:0]     r_to,    w_to_nxt;

    logic [7:0] w_entry_addr;
    logic [7:0] w_entry_data;
    logic       w_ms_tick;
    state_t     w_adv_state;
    logic [7:0] w_adv_index;

    always_comb begin
        case (r_index)
            8'd0:    {w_entry_addr, w_entry_data} = 16'h1280;
            8'd1:    {w_entry_addr, w_entry_data} = 16'hF00A;
            8'd2:    {w_entry_addr, w_entry_data} = 16'h1204;
            8'd3:    {w_entry_addr, w_entry_data} = 16'h1101;
            8'd4:    {w_entry_addr, w_entry_data} = 16'h0C00;
            8'd5:    {w_entry_addr, w_entry_data} = 16'h3E00;
            8'd6:    {w_entry_addr, w_entry_data} = 16'h40D0;
            8'd7:    {w_entry_addr, w_entry_data} = 16'h8C00;
            default: {w_entry_addr, w_entry_data} = 16'hFFFF;
        endcase
    end

    assign w_ms_tick = (r_tick == c_TICK_LAST);

    // Moving past the last index ends the table rather than wrapping to 0.
    assign w_adv_state = (r_index == 8'hFF) ? S_DONE : S_FETCH;
    assign w_adv_index = (r_index == 8'hFF) ? r_index : r_index + 8'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_index;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_tick_nxt  = '0;
        w_ms_nxt    = r_ms;
        w_to_nxt    = r_to;
        case (r_state)
            S_POWERUP_WAIT: begin
                w_tick_nxt = w_ms_tick ? '0 : r_tick + 1'b1;
                if (w_ms_tick) begin
                    if (r_ms == c_PU_LAST) begin
                        w_ms_nxt    = '0;
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_ms_nxt = r_ms + 8'd1;
                    end
                end
            end
            S_FETCH: begin
                w_ms_nxt = '0;
                if (w_entry_addr == 8'hFF && w_entry_data == 8'hFF) begin
                    w_state_nxt = S_DONE;
                end else if (w_entry_addr == 8'hF0) begin
                    if (w_entry_data == 8'h00) begin
                        w_state_nxt = w_adv_state;
                        w_index_nxt = w_adv_index;
                    end else begin
                        w_state_nxt = S_DELAY;
                    end
                end else begin
                    w_addr_nxt  = w_entry_addr;
                    w_data_nxt  = w_entry_data;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_DELAY: begin
                // Table entry stays addressed by r_index, so its data is the delay length.
                w_tick_nxt = w_ms_tick ? '0 : r_tick + 1'b1;
                if (w_ms_tick) begin
                    if (r_ms == w_entry_data - 8'd1) begin
                        w_ms_nxt    = '0;
                        w_state_nxt = w_adv_state;
                        w_index_nxt = w_adv_index;
                    end else begin
                        w_ms_nxt = r_ms + 8'd1;
                    end
                end
            end
            S_ISSUE: begin
                w_to_nxt = '0;
                if (!i_sccb_busy) begin
                    w_state_nxt = S_WAIT_BUSY_HI;
                end
            end
            S_WAIT_BUSY_HI: begin
                if (i_sccb_busy) begin
                    w_state_nxt = S_WAIT_BUSY_LO;
                end else if (r_to == c_TO_LAST) begin
                    w_state_nxt = S_ERROR;
                end else begin
                    w_to_nxt = r_to + 1'b1;
                end
            end
            S_WAIT_BUSY_LO: begin
                if (!i_sccb_busy) begin
                    w_state_nxt = w_adv_state;
                    w_index_nxt = w_adv_index;
                end
            end
            S_DONE, S_ERROR: begin
                if (i_start) begin
                    w_index_nxt = '0;
                    w_state_nxt = S_FETCH;
                end
            end
            default: w_state_nxt = S_POWERUP_WAIT;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_POWERUP_WAIT;
            r_index <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_tick  <= '0;
            r_ms    <= '0;
            r_to    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_index <= w_index_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            r_tick  <= w_tick_nxt;
            r_ms    <= w_ms_nxt;
            r_to    <= w_to_nxt;
        end
    end

    // Strobe is gated by busy directly so it can never coincide with a busy master.
    assign o_sccb_ready = (r_state == S_ISSUE) && !i_sccb_busy;
    assign o_sccb_addr  = r_addr;
    assign o_sccb_data  = r_data;
    assign o_index      = r_index;
    assign o_done       = (r_state == S_DONE);
    assign o_error      = (r_state == S_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_ov7670_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_ov7670_config_sequencer
// Brief   : Directed bench with an SCCB busy model and an expected-write queue.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ov7670_config_sequencer;

    logic       clk;
    logic       rst_n;
    logic       i_start;
    logic       model_busy;
    logic       force_busy;
    logic       model_en;
    wire        w_busy;
    wire  [7:0] w_addr;
    wire  [7:0] w_data;
    wire        w_ready;
    wire  [7:0] w_index;
    wire        w_done;
    wire        w_error;

    int n_tests;
    int n_fail;
    int cyc;
    int strobe_cnt;
    int last_strobe_cyc;
    int strobe_cyc [256];
    int fall_cyc   [256];
    logic [23:0] sb [$];
    logic [15:0] tbl [0:8];

    assign w_busy = model_busy | force_busy;

    ov7670_config_sequencer #(
        .ClockFrequency   (1_000_000),
        .PowerUpDelayMs   (10),
        .BusyTimeoutCycles(1024)
    ) dut (
        .CLK         (clk),
        .RST         (rst_n),
        .i_start     (i_start),
        .i_sccb_busy (w_busy),
        .o_sccb_addr (w_addr),
        .o_sccb_data (w_data),
        .o_sccb_ready(w_ready),
        .o_index     (w_index),
        .o_done      (w_done),
        .o_error     (w_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        #1;
    endtask

    // Expected writes for table entries 0..upto, skipping markers.
    task automatic push_run(input int upto);
        for (int i = 0; i <= upto; i++) begin
            if (tbl[i][15:8] != 8'hF0 && tbl[i] != 16'hFFFF)
                sb.push_back({8'(i), tbl[i]});
        end
    endtask

    task automatic wait_strobe(input int base, input int budget, input string tag);
        for (int k = 0; k < budget && strobe_cnt <= base; k++) tick();
        check(tag, 32'(strobe_cnt > base), 32'd1);
    endtask

    task automatic wait_done(input int budget, input string tag);
        for (int k = 0; k < budget && !w_done && !w_error; k++) tick();
        check(tag, 32'(w_done), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(w_ready), 32'd0);
        check({tag, "_addr"},  32'(w_addr),  32'd0);
        check({tag, "_data"},  32'(w_data),  32'd0);
        check({tag, "_index"}, 32'(w_index), 32'd0);
        check({tag, "_done"},  32'(w_done),  32'd0);
        check({tag, "_error"}, 32'(w_error), 32'd0);
    endtask

    // SCCB master model: busy rises ~2 cycles after a strobe and holds for 50 cycles.
    initial begin
        model_busy = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (model_en && rst_n && w_ready) begin
                @(negedge clk);
                @(negedge clk);
                model_busy = 1'b1;
                repeat (50) @(negedge clk);
                model_busy = 1'b0;
            end
        end
    end

    // Scoreboard side: every strobe pops one expected {index,addr,data}.
    initial begin
        logic [23:0] exp;
        logic        prev_busy;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && w_ready) begin
                strobe_cnt++;
                strobe_cyc[w_index] = cyc;
                last_strobe_cyc     = cyc;
                if (sb.size() > 0) exp = sb.pop_front();
                else               exp = 24'hFFFFFF;
                check("strobe_entry", {8'h00, w_index, w_addr, w_data}, {8'h00, exp});
                check("strobe_busy_low", 32'(w_busy), 32'd0);
            end
            if (prev_busy && !w_busy) fall_cyc[w_index] = cyc;
            prev_busy = w_busy;
        end
    end

    initial begin
        int r_cyc;
        int s0;
        int d;
        tbl = '{16'h1280, 16'hF00A, 16'h1204, 16'h1101, 16'h0C00,
                16'h3E00, 16'h40D0, 16'h8C00, 16'hFFFF};
        n_tests = 0;  n_fail = 0;  cyc = 0;  strobe_cnt = 0;  last_strobe_cyc = 0;
        rst_n = 1'b0;  i_start = 1'b0;  force_busy = 1'b0;  model_en = 1'b1;

        // Reset state, then first run from power-up
        repeat (5) tick();
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        r_cyc = cyc;
        s0    = strobe_cnt;
        push_run(8);
        wait_strobe(s0, 10100, "first_strobe_seen");
        d = last_strobe_cyc - r_cyc;
        check("powerup_latency", 32'(d >= 10000 && d <= 10005), 32'd1);
        wait_done(25000, "run1_done");
        check("run1_index", 32'(w_index), 32'd8);
        check("run1_strobes", 32'(strobe_cnt - s0), 32'd7);
        check("run1_error", 32'(w_error), 32'd0);
        check("delay_gap", 32'(strobe_cyc[2] - fall_cyc[0] >= 10000), 32'd1);
        // busy falls mid-cycle; that cycle plus FETCH and ISSUE puts the strobe 2 counts later
        check("fall_to_strobe", 32'(strobe_cyc[3] - fall_cyc[2]), 32'd2);

        // Busy never rises -> timeout, then recover with i_start
        model_en = 1'b0;
        s0 = strobe_cnt;
        push_run(0);
        pulse_start();
        wait_strobe(s0, 20, "to_strobe_seen");
        for (int k = 0; k < 1100 && !w_error; k++) tick();
        check("to_error", 32'(w_error), 32'd1);
        d = cyc - last_strobe_cyc;
        check("to_latency", 32'(d >= 1023 && d <= 1026), 32'd1);
        check("to_index", 32'(w_index), 32'd0);
        check("to_done", 32'(w_done), 32'd0);
        repeat (100) tick();
        check("to_no_strobes", 32'(strobe_cnt - s0), 32'd1);
        model_en = 1'b1;
        s0 = strobe_cnt;
        push_run(8);
        pulse_start();
        check("recover_error_clr", 32'(w_error), 32'd0);
        wait_done(15000, "recover_done");
        check("recover_strobes", 32'(strobe_cnt - s0), 32'd7);

        // Reset while the entry-4 transfer is busy
        push_run(4);
        pulse_start();
        for (int k = 0; k < 15000 && !(w_index == 8'd4 && w_busy); k++) tick();
        check("idx4_busy_reached", 32'(w_index == 8'd4 && w_busy), 32'd1);
        repeat (3) tick();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        force_busy = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        r_cyc = cyc;
        s0    = strobe_cnt;
        push_run(8);
        // Busy held past the point the first strobe would otherwise go out
        while (cyc - r_cyc < 10200) tick();
        check("held_no_strobe", 32'(strobe_cnt - s0), 32'd0);
        check("held_index", 32'(w_index), 32'd0);
        @(negedge clk);
        force_busy = 1'b0;
        wait_strobe(s0, 20, "held_strobe_seen");
        check("held_latency", 32'(last_strobe_cyc - r_cyc >= 10200), 32'd1);
        for (int k = 0; k < 15000 && w_index != 8'd3; k++) tick();
        pulse_start();
        check("midrun_start_index", 32'(w_index), 32'd3);
        wait_done(15000, "midrun_done");
        check("midrun_index", 32'(w_index), 32'd8);
        check("midrun_strobes", 32'(strobe_cnt - s0), 32'd7);

        // Rerun from DONE
        s0 = strobe_cnt;
        push_run(8);
        pulse_start();
        check("rerun_done_clr", 32'(w_done), 32'd0);
        check("rerun_index", 32'(w_index), 32'd0);
        wait_done(15000, "rerun_done");
        check("rerun_strobes", 32'(strobe_cnt - s0), 32'd7);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
